pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle MIPS core. It owns the word-addressed program counter and selects each cycle between sequential advance, taken branch, jump and hold. A small state machine sequences the core from reset through a boot wait into run, and parks it on halt. It also keeps a retired-instruction count. It sits between the control/branch-compare logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the word-addressed program counter, sequences
// IDLE -> BOOT -> RUN -> HALT, and keeps a saturating retired-instruction count.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int unsigned BOOT_WAIT   = 4,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LOAD = (BOOT_WAIT == 0) ? 8'd0 : 8'(BOOT_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  boot_q, boot_d;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pc_plus1      = pc_q + 32'd1;
    assign branch_target = pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
    assign jump_target   = {pc_plus1[31:26], jump_index};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            count_q <= COUNT_RESET;
            boot_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            boot_q  <= boot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        boot_d  = boot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (BOOT_WAIT == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = BOOT;
                        boot_d  = BOOT_LOAD;
                    end
                end
            end
            BOOT: begin
                if (boot_q == 8'd0) state_d = RUN;
                else                boot_d  = boot_q - 8'd1;
            end
            RUN: begin
                // Stalled redirects are dropped; control re-issues them.
                if (halt) begin
                    state_d = HALT;
                end else if (!stall) begin
                    if (jump)              pc_d = jump_target;
                    else if (branch_taken) pc_d = branch_target;
                    else                   pc_d = pc_plus1;
                    if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = pc_plus1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign instr_count = count_q;
    assign fetch_valid = (state_q == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirect, halt/resume, stall, wrap,
// async reset and count saturation across three parameterisations.
module tb_pc_sequencer;

    logic        clk;
    logic        rst1, rst2, rst3;
    logic        start, halt, stall, branch_taken, jump;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;

    logic [31:0] pc1, pp1, cnt1;
    logic [31:0] pc2, pp2, cnt2;
    logic [31:0] pc3, pp3, cnt3;
    logic        fv1, fv2, fv3;
    logic [1:0]  st1, st2, st3;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_VEC(32'h0000_0100), .BOOT_WAIT(4)) u1 (
        .clk(clk), .reset(rst1), .start(start), .halt(halt), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .pc(pc1), .pc_plus1(pp1),
        .fetch_valid(fv1), .state(st1), .instr_count(cnt1));

    pc_sequencer #(.RESET_VEC(32'hFFFF_FFFE), .BOOT_WAIT(0)) u2 (
        .clk(clk), .reset(rst2), .start(start), .halt(halt), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .pc(pc2), .pc_plus1(pp2),
        .fetch_valid(fv2), .state(st2), .instr_count(cnt2));

    pc_sequencer #(.RESET_VEC(32'h4000_0005), .BOOT_WAIT(0),
                   .COUNT_RESET(32'hFFFF_FFFD)) u3 (
        .clk(clk), .reset(rst3), .start(start), .halt(halt), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .pc(pc3), .pc_plus1(pp3),
        .fetch_valid(fv3), .state(st3), .instr_count(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_u1(input string tag, input logic [1:0] st, input logic [31:0] p,
                            input logic [31:0] c);
        check({tag, " state"}, {30'd0, st1}, {30'd0, st});
        check({tag, " pc"}, pc1, p);
        check({tag, " count"}, cnt1, c);
        check({tag, " fetch_valid"}, {31'd0, fv1}, {31'd0, (st == 2'd2)});
    endtask

    initial begin
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        start = 1'b0; halt = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 16'h0; jump_index = 26'h0;

        // Reset held for three cycles
        repeat (3) step();
        check_u1("reset", 2'd0, 32'h100, 32'd0);
        check("reset pc_plus1", pp1, 32'h101);

        // Boot: four cycles in BOOT, RUN on the fifth edge
        rst1 = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_u1("boot", 2'd1, 32'h100, 32'd0);
        end
        step();
        check_u1("run entry", 2'd2, 32'h100, 32'd0);
        step();
        check_u1("seq1", 2'd2, 32'h101, 32'd1);
        step();
        check_u1("seq2", 2'd2, 32'h102, 32'd2);

        // Redirects
        jump = 1'b1; jump_index = 26'h10;
        step();
        check_u1("jump to 10", 2'd2, 32'h10, 32'd3);
        jump = 1'b0; branch_taken = 1'b1; branch_offset = 16'hFFFC;
        step();
        check_u1("branch back", 2'd2, 32'h0D, 32'd4);
        jump = 1'b1; jump_index = 26'h20; branch_offset = 16'h0005;
        step();
        check_u1("jump beats branch", 2'd2, 32'h20, 32'd5);

        // Halt with stall also set; HALT ignores redirect inputs
        jump = 1'b0; branch_taken = 1'b0; start = 1'b0;
        halt = 1'b1; stall = 1'b1;
        step();
        check_u1("halt", 2'd3, 32'h20, 32'd5);
        halt = 1'b0; stall = 1'b0; jump = 1'b1; jump_index = 26'h3FF;
        for (int i = 0; i < 5; i++) begin
            step();
            check_u1("halted", 2'd3, 32'h20, 32'd5);
        end
        jump = 1'b0; start = 1'b1;
        step();
        check_u1("resume", 2'd2, 32'h21, 32'd5);
        start = 1'b0;

        // Stall drops a concurrent jump
        stall = 1'b1; jump = 1'b1; jump_index = 26'h30;
        for (int i = 0; i < 3; i++) begin
            step();
            check_u1("stall", 2'd2, 32'h21, 32'd5);
        end
        stall = 1'b0; jump = 1'b0;
        step();
        check_u1("after stall", 2'd2, 32'h22, 32'd6);
        jump = 1'b1; jump_index = 26'h37;
        step();
        check_u1("jump to 37", 2'd2, 32'h37, 32'd7);
        jump = 1'b0;

        // Async reset between edges
        #2 rst1 = 1'b0;
        #1;
        check_u1("async reset", 2'd0, 32'h100, 32'd0);
        step();
        rst1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_u1("idle hold", 2'd0, 32'h100, 32'd0);
        end
        start = 1'b1;
        step();
        check_u1("restart boot", 2'd1, 32'h100, 32'd0);
        start = 1'b0;

        // Wrap with BOOT_WAIT=0
        check("u2 reset pc", pc2, 32'hFFFF_FFFE);
        check("u2 reset state", {30'd0, st2}, 32'd0);
        rst2 = 1'b1; start = 1'b1;
        step();
        check("u2 run entry state", {30'd0, st2}, 32'd2);
        check("u2 run entry fv", {31'd0, fv2}, 32'd1);
        check("u2 pc0", pc2, 32'hFFFF_FFFE);
        step();
        check("u2 pc1", pc2, 32'hFFFF_FFFF);
        check("u2 pc_plus1 wrap", pp2, 32'h0);
        step();
        check("u2 pc wrap", pc2, 32'h0000_0000);
        check("u2 count", cnt2, 32'd2);

        // High-page jump and count saturation
        rst3 = 1'b1;
        step();
        check("u3 run entry pc", pc3, 32'h4000_0005);
        check("u3 run entry count", cnt3, 32'hFFFF_FFFD);
        start = 1'b0; jump = 1'b1; jump_index = 26'h0000_200;
        step();
        check("u3 jump high page", pc3, 32'h4000_0200);
        check("u3 count", cnt3, 32'hFFFF_FFFE);
        jump = 1'b0;
        step();
        check("u3 count max", cnt3, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("u3 count saturated", cnt3, 32'hFFFF_FFFF);
        end
        check("u3 pc seq", pc3, 32'h4000_0204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
